// File: rtl/covariance_accum_if.sv
// Handshake and result bus of the 4-channel covariance accumulator.
// The master drives the start pulse and the centered samples. The slave
// (the accumulator) returns the sample-ready flag and the stream of
// covariance entries.
interface covariance_accum_if #(
    parameter int DATA_W = 26
);
    logic                     GO;
    logic                     in_valid;
    logic signed [DATA_W-1:0] x1_in;
    logic signed [DATA_W-1:0] x2_in;
    logic signed [DATA_W-1:0] x3_in;
    logic signed [DATA_W-1:0] x4_in;
    logic                     in_ready;
    logic signed [DATA_W-1:0] cov_out;
    logic [3:0]               cov_idx;
    logic                     cov_valid;
    logic                     cov_last;
    logic                     busy;

    modport master (
        output GO, in_valid, x1_in, x2_in, x3_in, x4_in,
        input  in_ready, cov_out, cov_idx, cov_valid, cov_last, busy
    );

    modport slave (
        input  GO, in_valid, x1_in, x2_in, x3_in, x4_in,
        output in_ready, cov_out, cov_idx, cov_valid, cov_last, busy
    );
endinterface

// File: rtl/covariance_accum.sv
// Covariance accumulator for four centered channels.
// Each accepted sample is multiplied out over the 10 unique channel pairs,
// at one product per cycle. The products go into wide accumulators that
// cannot overflow. After 2^N_LOG2 samples the 10 entries are streamed out.
// Each entry is scaled by 2^-(FRAC+N_LOG2) using an arithmetic (floor) shift
// and then saturated to DATA_W bits.
module covariance_accum #(
    parameter int DATA_W = 26,
    parameter int FRAC   = 12,
    parameter int N_LOG2 = 10
) (
    input  logic               clk,
    input  logic               rst,
    covariance_accum_if.slave  bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + N_LOG2;
    localparam int SHIFT  = FRAC + N_LOG2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        MAC    = 2'd2,
        EMIT   = 2'd3
    } state_t;

    state_t                    state_r;
    state_t                    state_next;
    logic signed [ACC_W-1:0]   acc_r [0:9];
    logic signed [DATA_W-1:0]  x_r [0:3];
    logic [3:0]                pair_r;
    logic [N_LOG2-1:0]         cnt_r;
    logic [3:0]                k_r;

    logic                      in_ready_r;
    logic                      busy_r;
    logic                      cov_valid_r;
    logic                      cov_last_r;
    logic signed [DATA_W-1:0]  cov_out_r;
    logic [3:0]                cov_idx_r;

    logic signed [DATA_W-1:0]  op_a_s;
    logic signed [DATA_W-1:0]  op_b_s;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   prod_ext_s;
    logic signed [ACC_W-1:0]   emit_acc_s;
    logic                      busy_s;
    logic                      last_sample_s;

    // First channel of pair p: (1,1)(1,2)(1,3)(1,4)(2,2)(2,3)(2,4)(3,3)(3,4)(4,4)
    function automatic logic [1:0] pair_first(input logic [3:0] p);
        case (p)
            4'd0, 4'd1, 4'd2, 4'd3: pair_first = 2'd0;
            4'd4, 4'd5, 4'd6:       pair_first = 2'd1;
            4'd7, 4'd8:             pair_first = 2'd2;
            default:                pair_first = 2'd3;
        endcase
    endfunction

    // Second channel of pair p in the same fixed order
    function automatic logic [1:0] pair_second(input logic [3:0] p);
        case (p)
            4'd0:             pair_second = 2'd0;
            4'd1, 4'd4:       pair_second = 2'd1;
            4'd2, 4'd5, 4'd7: pair_second = 2'd2;
            default:          pair_second = 2'd3;
        endcase
    endfunction

    // Floor-scale an accumulator by 2^-SHIFT and clamp it to the signed result range
    function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> SHIFT;
        if (sh[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){sh[ACC_W-1]}}) begin
            sat_shift = sh[DATA_W-1:0];
        end else if (sh[ACC_W-1]) begin
            sat_shift = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_shift = {1'b0, {(DATA_W-1){1'b1}}};
        end
    endfunction

    // Operand selection and full-precision product for the current pair
    always_comb begin
        op_a_s     = x_r[pair_first(pair_r)];
        op_b_s     = x_r[pair_second(pair_r)];
        prod_s     = PROD_W'(op_a_s) * PROD_W'(op_b_s);
        prod_ext_s = ACC_W'(prod_s);
    end

    // Select the accumulator being emitted this cycle
    always_comb begin
        emit_acc_s = '0;
        case (k_r)
            4'd0:    emit_acc_s = acc_r[0];
            4'd1:    emit_acc_s = acc_r[1];
            4'd2:    emit_acc_s = acc_r[2];
            4'd3:    emit_acc_s = acc_r[3];
            4'd4:    emit_acc_s = acc_r[4];
            4'd5:    emit_acc_s = acc_r[5];
            4'd6:    emit_acc_s = acc_r[6];
            4'd7:    emit_acc_s = acc_r[7];
            4'd8:    emit_acc_s = acc_r[8];
            4'd9:    emit_acc_s = acc_r[9];
            default: emit_acc_s = '0;
        endcase
    end

    // Next-state decode; GO only matters from IDLE
    always_comb begin
        state_next    = state_r;
        last_sample_s = &cnt_r;
        case (state_r)
            IDLE: begin
                if (bus.GO) state_next = ACCEPT;
                else        state_next = IDLE;
            end
            ACCEPT: begin
                if (bus.in_valid) state_next = MAC;
                else              state_next = ACCEPT;
            end
            MAC: begin
                if (pair_r == 4'd9) begin
                    if (last_sample_s) state_next = EMIT;
                    else               state_next = ACCEPT;
                end else begin
                    state_next = MAC;
                end
            end
            EMIT: begin
                if (k_r == 4'd9) state_next = IDLE;
                else             state_next = EMIT;
            end
            default: state_next = IDLE;
        endcase
        busy_s = (state_next != IDLE) || (state_r == EMIT);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_next;
    end

    // Registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            cov_valid_r <= 1'b0;
            cov_last_r  <= 1'b0;
            cov_out_r   <= '0;
            cov_idx_r   <= 4'd0;
        end else begin
            in_ready_r  <= (state_next == ACCEPT);
            busy_r      <= busy_s;
            cov_valid_r <= (state_r == EMIT);
            cov_last_r  <= (state_r == EMIT) && (k_r == 4'd9);
            if (state_r == EMIT) begin
                cov_out_r <= sat_shift(emit_acc_s);
                cov_idx_r <= k_r;
            end
        end
    end

    // Sample latch, pair/sample/emit counters and accumulators
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) acc_r[i] <= '0;
            for (int i = 0; i < 4; i++)  x_r[i]   <= '0;
            pair_r <= 4'd0;
            cnt_r  <= '0;
            k_r    <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.GO) begin
                        for (int i = 0; i < 10; i++) acc_r[i] <= '0;
                        cnt_r <= '0;
                    end
                end
                ACCEPT: begin
                    if (bus.in_valid) begin
                        x_r[0] <= bus.x1_in;
                        x_r[1] <= bus.x2_in;
                        x_r[2] <= bus.x3_in;
                        x_r[3] <= bus.x4_in;
                        pair_r <= 4'd0;
                    end
                end
                MAC: begin
                    for (int i = 0; i < 10; i++) begin
                        if (pair_r == 4'(i)) acc_r[i] <= acc_r[i] + prod_ext_s;
                    end
                    if (pair_r == 4'd9) begin
                        pair_r <= 4'd0;
                        k_r    <= 4'd0;
                        if (!last_sample_s) cnt_r <= cnt_r + {{(N_LOG2-1){1'b0}}, 1'b1};
                    end else begin
                        pair_r <= pair_r + 4'd1;
                    end
                end
                EMIT: begin
                    k_r <= k_r + 4'd1;
                end
                default: begin
                    pair_r <= 4'd0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.busy      = busy_r;
    assign bus.cov_valid = cov_valid_r;
    assign bus.cov_last  = cov_last_r;
    assign bus.cov_out   = cov_out_r;
    assign bus.cov_idx   = cov_idx_r;
endmodule

// File: tb/tb_covariance_accum.sv
// Directed bench for covariance_accum (FRAC=0, N_LOG2=2).
// Expected entries are queued when a pass is driven. A negedge monitor pops
// and compares them against the emitted entries. The same monitor checks
// that in_ready does not return sooner than 11 cycles after an acceptance.
module tb_covariance_accum;
    localparam int DW = 26;
    localparam int FR = 0;
    localparam int NL = 2;
    localparam int NS = 4;
    localparam int SH = FR + NL;
    localparam longint MAXV = (64'sd1 <<< (DW - 1)) - 64'sd1;
    localparam longint MINV = -(64'sd1 <<< (DW - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;

    covariance_accum_if #(.DATA_W(DW)) bus();

    covariance_accum #(.DATA_W(DW), .FRAC(FR), .N_LOG2(NL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     idx;
        longint val;
    } exp_t;

    exp_t   exp_q[$];
    longint smp[NS][4];
    longint cl[10];
    int     ia[10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
    int     ib[10] = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};

    int compared     = 0;
    int failed       = 0;
    int cyc          = 0;
    int acc_total    = 0;
    int acc_edge     = -100;
    int last_checked = -100;
    int last_count   = 0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Edge counter and accepted-sample bookkeeping
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus.in_ready && bus.in_valid) begin
            acc_total <= acc_total + 1;
            acc_edge  <= cyc + 1;
        end
    end

    // Scoreboard compare of emitted entries and ready-gap check
    always @(negedge clk) begin
        exp_t e;
        int   gap;
        if (!rst && bus.cov_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_entry_idx", bus.cov_idx, -1);
            end else begin
                e = exp_q.pop_front();
                check("cov_idx", bus.cov_idx, e.idx);
                check("cov_out", $signed(bus.cov_out), e.val);
                check("cov_last", bus.cov_last, (e.idx == 9));
            end
            if (bus.cov_last) last_count <= last_count + 1;
        end
        if (!rst && bus.in_ready && acc_edge >= 0 && acc_edge != last_checked) begin
            gap = cyc - acc_edge + 1;
            compared++;
            assert (gap >= 11) else begin
                failed++;
                $error("FAIL ready_gap: observed %0d cycles expected >= 11", gap);
            end
            last_checked <= acc_edge;
        end
    end

    // Reference model: floor-shifted, saturated sums of pair products
    task automatic push_model();
        longint acc;
        longint sh;
        exp_t   e;
        for (int p = 0; p < 10; p++) begin
            acc = 0;
            for (int s = 0; s < NS; s++) acc += smp[s][ia[p]] * smp[s][ib[p]];
            sh = acc >>> SH;
            if (sh > MAXV) sh = MAXV;
            if (sh < MINV) sh = MINV;
            e.idx = p;
            e.val = sh;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_list();
        exp_t e;
        for (int p = 0; p < 10; p++) begin
            e.idx = p;
            e.val = cl[p];
            exp_q.push_back(e);
        end
    endtask

    task automatic set_all(input longint a, input longint b, input longint c, input longint d);
        for (int s = 0; s < NS; s++) begin
            smp[s][0] = a; smp[s][1] = b; smp[s][2] = c; smp[s][3] = d;
        end
    endtask

    task automatic pulse_go();
        @(negedge clk);
        bus.GO = 1'b1;
        @(negedge clk);
        bus.GO = 1'b0;
    endtask

    task automatic send_sample(input int s, input bit rnd);
        bit done = 1'b0;
        int guard = 0;
        while (!done && guard < 300) begin
            @(negedge clk);
            guard++;
            if (bus.in_ready && (!rnd || $urandom_range(0, 1) == 1)) begin
                bus.GO       = 1'b0;
                bus.in_valid = 1'b1;
                bus.x1_in    = DW'(smp[s][0]);
                bus.x2_in    = DW'(smp[s][1]);
                bus.x3_in    = DW'(smp[s][2]);
                bus.x4_in    = DW'(smp[s][3]);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                done = 1'b1;
            end else if (bus.in_ready) begin
                bus.in_valid = 1'b0;
                bus.GO       = 1'b0;
            end else begin
                bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.GO       = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
                bus.x1_in    = DW'($urandom);
                bus.x2_in    = DW'($urandom);
                bus.x3_in    = DW'($urandom);
                bus.x4_in    = DW'($urandom);
            end
        end
        if (!done) check("sample_accept_timeout", 0, 1);
    endtask

    task automatic run_pass(input bit rnd);
        int start_acc;
        int start_last;
        int guard = 0;
        start_acc  = acc_total;
        start_last = last_count;
        pulse_go();
        for (int s = 0; s < NS; s++) send_sample(s, rnd);
        bus.GO = 1'b0;
        bus.in_valid = 1'b0;
        while (last_count == start_last && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (last_count == start_last) check("pass_timeout", 0, 1);
        @(negedge clk);
        check("busy_after_pass", bus.busy, 0);
        check("valid_after_pass", bus.cov_valid, 0);
        check("queue_drained", exp_q.size(), 0);
        check("samples_consumed", acc_total - start_acc, NS);
    endtask

    initial begin
        bus.GO = 1'b0; bus.in_valid = 1'b0;
        bus.x1_in = '0; bus.x2_in = '0; bus.x3_in = '0; bus.x4_in = '0;

        // Reset with random inputs: all outputs held at zero
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            bus.GO = 1'($urandom_range(0, 1));
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.x1_in = DW'($urandom); bus.x2_in = DW'($urandom);
            bus.x3_in = DW'($urandom); bus.x4_in = DW'($urandom);
        end
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_cov_valid", bus.cov_valid, 0);
        check("rst_cov_last", bus.cov_last, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cov_out", bus.cov_out, 0);
        check("rst_cov_idx", bus.cov_idx, 0);
        bus.GO = 1'b1;
        @(negedge clk);
        bus.GO = 1'b0; bus.in_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("go_in_rst_busy", bus.busy, 0);
        check("go_in_rst_ready", bus.in_ready, 0);

        // Constant data (1,2,3,4)
        set_all(1, 2, 3, 4);
        cl = '{1, 2, 3, 4, 4, 6, 8, 9, 12, 16};
        push_list();
        run_pass(1'b0);
        repeat (2) @(negedge clk);
        check("hold_cov_idx", bus.cov_idx, 9);
        check("hold_cov_out", $signed(bus.cov_out), 16);

        // Signed data with cancelling cross terms
        smp[0] = '{2, -2, 0, 0}; smp[1] = '{-2, 2, 0, 0};
        smp[2] = '{2, -2, 0, 0}; smp[3] = '{-2, 2, 0, 0};
        cl = '{4, -4, 0, 0, 4, 0, 0, 0, 0, 0};
        push_list();
        run_pass(1'b0);

        // Positive saturation
        set_all(64'sd1 <<< 20, 0, 0, 0);
        cl = '{33554431, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        push_list();
        run_pass(1'b0);

        // Floor toward minus infinity: -5 / 4 -> -2
        set_all(0, 0, 0, 0);
        smp[0] = '{-5, 1, 0, 0};
        cl = '{6, -2, 0, 0, 0, 0, 0, 0, 0, 0};
        push_list();
        run_pass(1'b0);

        // Negative saturation on a cross term
        set_all(-(64'sd1 <<< 20), 64'sd1 <<< 20, 3, -7);
        push_model();
        run_pass(1'b0);

        // Random handshake, GO pulsed mid-pass, random data
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < NS; s++)
                for (int c = 0; c < 4; c++)
                    smp[s][c] = longint'($urandom_range(0, 8191)) - 64'sd4096;
            push_model();
            run_pass(1'b1);
        end

        // Reset in the middle of MAC for sample 3, then a clean pass
        set_all(9, -3, 5, 7);
        pulse_go();
        for (int s = 0; s < 3; s++) send_sample(s, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_cov_out", bus.cov_out, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("abandoned_busy", bus.busy, 0);
        set_all(1, 2, 3, 4);
        cl = '{1, 2, 3, 4, 4, 6, 8, 9, 12, 16};
        push_list();
        run_pass(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule

// File: doc/covariance_accum.md
COVARIANCE_ACCUM -- requirements
Module: covariance_accum

Interface
REQ-001 SHALL have parameter DATA_W, default 26, the width of the sample and result words (signed).
REQ-002 SHALL have parameter FRAC, default 12, the number of fractional bits in the sample and result fixed-point format.
REQ-003 SHALL have parameter N_LOG2, default 10, where N = 2^N_LOG2 is the number of samples per covariance pass.
REQ-004 Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- GO  in  1  start pulse for a covariance pass.
- in_valid  in  1  a centered sample is present on x1_in..x4_in.
- x1_in, x2_in, x3_in, x4_in  in  DATA_W each  centered sample channels, signed.
- in_ready  out  1  block will accept a sample this cycle.
- cov_out  out  DATA_W  covariance entry, signed.
- cov_idx  out  4  index of the entry on cov_out.
- cov_valid  out  1  cov_out and cov_idx are valid.
- cov_last  out  1  high with the final entry (idx 9).
- busy  out  1  a pass is in progress.

Function
REQ-005 SHALL implement FSM states IDLE, ACCEPT, MAC and EMIT; all outputs SHALL be registered.
REQ-006 IDLE: busy=0, in_ready=0; GO=1 SHALL clear all 10 accumulators and the sample counter, then go to ACCEPT.
REQ-007 GO SHALL be ignored in every state other than IDLE.
REQ-008 ACCEPT: busy=1, in_ready=1; when in_valid=1, the block SHALL latch x1..x4, set pair=0 and go to MAC; otherwise it SHALL stay in ACCEPT with no time limit.
REQ-009 MAC: in_ready=0; one product per cycle, acc[pair] += xi*xj (full-precision signed, 2*DATA_W bits; accumulator width 2*DATA_W+N_LOG2 bits, no overflow possible).
REQ-010 Pair order SHALL be fixed: 0:(1,1) 1:(1,2) 2:(1,3) 3:(1,4) 4:(2,2) 5:(2,3) 6:(2,4) 7:(3,3) 8:(3,4) 9:(4,4).
REQ-011 After pair 9: if sample count = N-1, the block SHALL go to EMIT with k=0; otherwise it SHALL increment the count and return to ACCEPT.
REQ-012 Throughput: a sample accepted in cycle t SHALL see in_ready high again no earlier than cycle t+11.
REQ-013 EMIT: for k=0..9, one entry per consecutive cycle with cov_valid=1 and cov_idx=k.
- cov_out = sat(acc[k] >>> (FRAC+N_LOG2)).
- The shift is arithmetic (floor toward minus infinity).
- Saturation range is [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-014 cov_last SHALL be 1 only together with k=9; the cycle after, the FSM SHALL return to IDLE with busy=0 and cov_valid=0.
REQ-015 The output path SHALL have no backpressure; the consumer must take each entry in the cycle it is presented.
REQ-016 cov_out and cov_idx SHALL hold their last values while cov_valid=0.
REQ-017 Samples presented while in_ready=0 SHALL be ignored and SHALL NOT be counted.

Reset
REQ-018 rst=1 SHALL immediately force IDLE and clear accumulators, counters and latched samples; in_ready, cov_valid, cov_last and busy SHALL go to 0; cov_out and cov_idx SHALL go to 0.
REQ-019 A reset during ACCEPT, MAC or EMIT SHALL abandon the pass; no further cov_valid SHALL occur until a new GO.

Verification (directed; the bench sets FRAC=0, N_LOG2=2 unless noted)
REQ-020 Reset check: assert rst with random inputs -> all outputs 0 and busy=0; GO before rst is released -> no effect.
REQ-021 Constant data: 4 samples of (1,2,3,4) -> entries idx 0..9 = 1,2,3,4,4,6,8,9,12,16; cov_last at idx 9.
REQ-022 Signed data: samples (2,-2,0,0), (-2,2,0,0) repeated twice -> idx0=4, idx1=-4, idx4=4, all others 0.
REQ-023 Floor and saturation:
- 4 samples x1=2^20, others 0 -> idx0=33554431 (saturated).
- 4 samples with x1*x2 summing to -5 over N=4 -> idx1=-2.
REQ-024 Handshake: in_valid toggled randomly and GO pulsed mid-pass -> exactly N samples consumed, ready gap of at least 11 cycles, GO ignored, results match the reference model.
REQ-025 Reset mid-MAC of sample 3, then a new GO with the REQ-021 data -> the REQ-021 results exactly, with no stale accumulation.
